// File: rtl/single_cycle_pkg.sv
// Shared encodings for the single-cycle ALU processor: opcodes, funct codes,
// ALU operation enum, control bundle and instruction field positions.
package single_cycle_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ADDIU = 6'd9;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_SLTIU = 6'd11;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_XORI  = 6'd14;
    localparam logic [5:0] OP_LUI   = 6'd15;

    localparam logic [5:0] FN_SLL  = 6'd0;
    localparam logic [5:0] FN_SRL  = 6'd2;
    localparam logic [5:0] FN_SRA  = 6'd3;
    localparam logic [5:0] FN_ADD  = 6'd32;
    localparam logic [5:0] FN_ADDU = 6'd33;
    localparam logic [5:0] FN_SUB  = 6'd34;
    localparam logic [5:0] FN_SUBU = 6'd35;
    localparam logic [5:0] FN_AND  = 6'd36;
    localparam logic [5:0] FN_OR   = 6'd37;
    localparam logic [5:0] FN_XOR  = 6'd38;
    localparam logic [5:0] FN_NOR  = 6'd39;
    localparam logic [5:0] FN_SLT  = 6'd42;
    localparam logic [5:0] FN_SLTU = 6'd43;

    localparam int OP_MSB = 31, OP_LSB = 26;
    localparam int RS_MSB = 25, RS_LSB = 21;
    localparam int RT_MSB = 20, RT_LSB = 16;
    localparam int RD_MSB = 15, RD_LSB = 11;
    localparam int SH_MSB = 10, SH_LSB = 6;
    localparam int FN_MSB = 5,  FN_LSB = 0;
    localparam int IM_MSB = 15, IM_LSB = 0;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_ADDU, ALU_SUB, ALU_SUBU,
        ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
    } alu_op_e;

    typedef struct packed {
        logic    reg_dst;
        logic    alu_src_b;
        logic    reg_write;
        alu_op_e alu_op;
    } ctrl_t;

endpackage

// File: rtl/single_cycle_alu_proc_alu.sv
// Combinational ALU: arithmetic, logic, compares and shifts with flag outputs.
module alu_unit
    import single_cycle_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    input  alu_op_e     alu_op,
    output logic [31:0] result,
    output logic        zero,
    output logic        carry_out,
    output logic        overflow
);

    logic [32:0] sum;
    logic [32:0] diff;

    // diff[32] is the carry out of a + ~b + 1, i.e. NOT borrow
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} + {1'b0, ~b} + 33'd1;

    always_comb begin
        result    = sum[31:0];
        carry_out = 1'b0;
        overflow  = 1'b0;
        unique case (alu_op)
            ALU_ADD, ALU_ADDU: begin
                result    = sum[31:0];
                carry_out = sum[32];
                overflow  = (alu_op == ALU_ADD) && (a[31] == b[31]) && (sum[31] != a[31]);
            end
            ALU_SUB, ALU_SUBU: begin
                result    = diff[31:0];
                carry_out = diff[32];
                overflow  = (alu_op == ALU_SUB) && (a[31] != b[31]) && (diff[31] != a[31]);
            end
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NOR:  result = ~(a | b);
            ALU_SLT:  result = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: result = {31'd0, a < b};
            ALU_SLL:  result = b << shamt;
            ALU_SRL:  result = b >> shamt;
            ALU_SRA:  result = $signed(b) >>> shamt;
            ALU_LUI:  result = {b[15:0], 16'h0000};
            default:  result = sum[31:0];
        endcase
    end

    assign zero = (result == 32'd0);

endmodule

// File: rtl/single_cycle_alu_proc.sv
// Single-cycle register-to-register MIPS-subset core: PC, instruction ROM,
// 32x32 register file, decode and ALU. ALU result is exported on dmemOut.
module single_cycle_alu_proc
    import single_cycle_pkg::*;
#(
    parameter int    IMEM_WORDS = 64,
    parameter string IMEM_INIT  = "imem.hex"
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] startPC,
    output logic [31:0] dmemOut
);

    localparam int IDX_W = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;

    logic [31:0] imem [IMEM_WORDS];
    logic [31:0] regs [32];
    logic [31:0] pc_q, pc, instr;
    logic [29:0] word_idx;
    ctrl_t       ctrl;

    // PC follows startPC combinationally while Reset is held, not just at edges
    assign pc = Reset ? startPC : pc_q;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) pc_q <= startPC;
        else       pc_q <= pc_q + 32'd4;
    end

    assign word_idx = pc[31:2];
    assign instr    = ({2'b00, word_idx} < 32'(IMEM_WORDS)) ? imem[word_idx[IDX_W-1:0]] : 32'd0;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt, rw;
    logic [31:0] imm_ext, bus_a, bus_b, alu_b, alu_result;
    logic        alu_zero, alu_carry, alu_ovf;

    assign op      = instr[OP_MSB:OP_LSB];
    assign rs      = instr[RS_MSB:RS_LSB];
    assign rt      = instr[RT_MSB:RT_LSB];
    assign rd      = instr[RD_MSB:RD_LSB];
    assign shamt   = instr[SH_MSB:SH_LSB];
    assign funct   = instr[FN_MSB:FN_LSB];
    assign imm_ext = {{16{instr[IM_MSB]}}, instr[IM_MSB:IM_LSB]};

    always_comb begin
        ctrl = '{reg_dst: 1'b0, alu_src_b: 1'b0, reg_write: 1'b0, alu_op: ALU_ADD};
        if (op == OP_RTYPE) begin
            ctrl.reg_dst   = 1'b1;
            ctrl.reg_write = 1'b1;
            case (funct)
                FN_SLL:  ctrl.alu_op = ALU_SLL;
                FN_SRL:  ctrl.alu_op = ALU_SRL;
                FN_SRA:  ctrl.alu_op = ALU_SRA;
                FN_ADD:  ctrl.alu_op = ALU_ADD;
                FN_ADDU: ctrl.alu_op = ALU_ADDU;
                FN_SUB:  ctrl.alu_op = ALU_SUB;
                FN_SUBU: ctrl.alu_op = ALU_SUBU;
                FN_AND:  ctrl.alu_op = ALU_AND;
                FN_OR:   ctrl.alu_op = ALU_OR;
                FN_XOR:  ctrl.alu_op = ALU_XOR;
                FN_NOR:  ctrl.alu_op = ALU_NOR;
                FN_SLT:  ctrl.alu_op = ALU_SLT;
                FN_SLTU: ctrl.alu_op = ALU_SLTU;
                default: ctrl.reg_write = 1'b0;
            endcase
        end else begin
            ctrl.alu_src_b = 1'b1;
            ctrl.reg_write = 1'b1;
            case (op)
                OP_ADDI:  ctrl.alu_op = ALU_ADD;
                OP_ADDIU: ctrl.alu_op = ALU_ADDU;
                OP_SLTI:  ctrl.alu_op = ALU_SLT;
                OP_SLTIU: ctrl.alu_op = ALU_SLTU;
                OP_ANDI:  ctrl.alu_op = ALU_AND;
                OP_ORI:   ctrl.alu_op = ALU_OR;
                OP_XORI:  ctrl.alu_op = ALU_XOR;
                OP_LUI:   ctrl.alu_op = ALU_LUI;
                default:  ctrl.reg_write = 1'b0;
            endcase
        end
    end

    assign rw    = ctrl.reg_dst ? rd : rt;
    assign bus_a = (rs == 5'd0) ? 32'd0 : regs[rs];
    assign bus_b = (rt == 5'd0) ? 32'd0 : regs[rt];
    assign alu_b = ctrl.alu_src_b ? imm_ext : bus_b;

    alu_unit u_alu (
        .a         (bus_a),
        .b         (alu_b),
        .shamt     (shamt),
        .alu_op    (ctrl.alu_op),
        .result    (alu_result),
        .zero      (alu_zero),
        .carry_out (alu_carry),
        .overflow  (alu_ovf)
    );

    // Overflow does not trap: the wrapped result is always committed
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else if (ctrl.reg_write && rw != 5'd0) begin
            regs[rw] <= alu_result;
        end
    end

    assign dmemOut = alu_result;

endmodule

// File: tb/tb_single_cycle_alu_proc.sv
// Directed program check for single_cycle_alu_proc: table of instructions with
// expected dmemOut, plus hand-written reset sequences.
module tb_single_cycle_alu_proc;

    localparam int NW = 32;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [31:0] startPC;
    logic [31:0] dmemOut;

    int checks = 0;
    int fails  = 0;

    single_cycle_alu_proc #(.IMEM_WORDS(NW), .IMEM_INIT("")) dut (
        .CLK     (CLK),
        .Reset   (Reset),
        .startPC (startPC),
        .dmemOut (dmemOut)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] instr;
        bit          chk;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vec [NW];

    function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic set_vec(input int i, input logic [31:0] ins, input bit c, input logic [31:0] e, input string n);
        vec[i].instr = ins; vec[i].chk = c; vec[i].exp = e; vec[i].name = n;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: dmemOut=%h expected=%h", name, act, exp);
        end
    endtask

    initial begin
        set_vec(0,  enc_i(6'd8,  5'd0, 5'd1, 16'd5),      1, 32'h00000005, "addi_r1_5");
        set_vec(1,  enc_i(6'd8,  5'd0, 5'd2, 16'hFFFD),   1, 32'hFFFFFFFD, "addi_r2_m3");
        set_vec(2,  enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'd32), 1, 32'h00000002, "add_r3");
        set_vec(3,  enc_r(5'd3, 5'd0, 5'd10, 5'd0, 6'd37),1, 32'h00000002, "read_r3");
        set_vec(4,  enc_r(5'd2, 5'd1, 5'd4, 5'd0, 6'd34), 1, 32'hFFFFFFF8, "sub");
        set_vec(5,  enc_r(5'd2, 5'd1, 5'd5, 5'd0, 6'd42), 1, 32'h00000001, "slt");
        set_vec(6,  enc_r(5'd2, 5'd1, 5'd6, 5'd0, 6'd43), 1, 32'h00000000, "sltu");
        set_vec(7,  enc_r(5'd0, 5'd0, 5'd7, 5'd0, 6'd39), 1, 32'hFFFFFFFF, "nor");
        set_vec(8,  enc_i(6'd15, 5'd0, 5'd8, 16'h1234),   1, 32'h12340000, "lui");
        set_vec(9,  enc_i(6'd13, 5'd8, 5'd8, 16'h0056),   1, 32'h12340056, "ori");
        set_vec(10, enc_r(5'd0, 5'd2, 5'd9, 5'd1, 6'd3),  1, 32'hFFFFFFFE, "sra");
        set_vec(11, enc_r(5'd0, 5'd2, 5'd9, 5'd28, 6'd2), 1, 32'h0000000F, "srl");
        set_vec(12, enc_i(6'd8,  5'd0, 5'd0, 16'd7),      1, 32'h00000007, "addi_r0");
        set_vec(13, enc_r(5'd0, 5'd0, 5'd10, 5'd0, 6'd37),1, 32'h00000000, "r0_still_0");
        set_vec(14, enc_i(6'd15, 5'd0, 5'd11, 16'h7FFF),  1, 32'h7FFF0000, "lui_r11");
        set_vec(15, enc_r(5'd0, 5'd7, 5'd11, 5'd1, 6'd2), 1, 32'h7FFFFFFF, "srl_max");
        set_vec(16, enc_i(6'd8,  5'd0, 5'd12, 16'd1),     1, 32'h00000001, "addi_one");
        set_vec(17, enc_r(5'd11, 5'd12, 5'd13, 5'd0, 6'd32), 1, 32'h80000000, "add_ovf");
        set_vec(18, enc_r(5'd13, 5'd0, 5'd14, 5'd0, 6'd37),  1, 32'h80000000, "ovf_written");
        set_vec(19, enc_i(6'd12, 5'd7, 5'd15, 16'h8000),  1, 32'hFFFF8000, "andi_sext");
        set_vec(20, 32'hFC010007,                         0, 32'h0,        "op63");
        set_vec(21, enc_r(5'd1, 5'd0, 5'd16, 5'd0, 6'd37),1, 32'h00000005, "op63_no_write");
        set_vec(22, enc_r(5'd0, 5'd2, 5'd1, 5'd0, 6'd1),  0, 32'h0,        "bad_funct");
        set_vec(23, enc_r(5'd1, 5'd0, 5'd16, 5'd0, 6'd37),1, 32'h00000005, "funct_no_write");
        set_vec(24, enc_i(6'd11, 5'd2, 5'd17, 16'hFFFF),  1, 32'h00000001, "sltiu_sext");
        set_vec(25, enc_i(6'd14, 5'd1, 5'd18, 16'hFFFF),  1, 32'hFFFFFFFA, "xori_sext");
        set_vec(26, enc_i(6'd10, 5'd2, 5'd19, 16'hFFFE),  1, 32'h00000001, "slti");
        set_vec(27, enc_i(6'd9,  5'd0, 5'd20, 16'hFFFF),  1, 32'hFFFFFFFF, "addiu");
        set_vec(28, enc_r(5'd0, 5'd1, 5'd21, 5'd0, 6'd35),1, 32'hFFFFFFFB, "subu");
        set_vec(29, enc_r(5'd0, 5'd1, 5'd22, 5'd4, 6'd0), 1, 32'h00000050, "sll");
        set_vec(30, enc_r(5'd1, 5'd2, 5'd23, 5'd0, 6'd38),1, 32'hFFFFFFF8, "xor");
        set_vec(31, enc_r(5'd1, 5'd2, 5'd24, 5'd0, 6'd36),1, 32'h00000005, "and");

        for (int i = 0; i < NW; i++) dut.imem[i] = vec[i].instr;

        // Reset held: dmemOut decodes the word at startPC and tracks it
        Reset   = 1'b1;
        startPC = 32'd4;
        @(negedge CLK);
        check("reset_pc4", dmemOut, 32'hFFFFFFFD);
        startPC = 32'd0;
        #1;
        check("reset_track_pc0", dmemOut, 32'h00000005);
        @(negedge CLK);
        check("reset_hold", dmemOut, 32'h00000005);
        Reset = 1'b0;
        #1;

        for (int i = 0; i < NW; i++) begin
            if (vec[i].chk) check(vec[i].name, dmemOut, vec[i].exp);
            @(negedge CLK);
        end

        // Past the end of the ROM: fetch returns the all-zero nop
        for (int i = 0; i < 3; i++) begin
            check("beyond_imem", dmemOut, 32'h00000000);
            @(negedge CLK);
        end

        // Mid-program reset between edges: word 2 (add r3,r1,r2) with cleared regs
        #2;
        startPC = 32'd8;
        Reset   = 1'b1;
        #1;
        check("midreset_regs_clear", dmemOut, 32'h00000000);
        @(negedge CLK);
        check("midreset_hold", dmemOut, 32'h00000000);
        Reset = 1'b0;
        #1;
        check("resume_w2_add",  dmemOut, 32'h00000000);
        @(negedge CLK);
        check("resume_w3_or",   dmemOut, 32'h00000000);
        @(negedge CLK);
        check("resume_w4_sub",  dmemOut, 32'h00000000);
        @(negedge CLK);
        check("resume_w5_slt",  dmemOut, 32'h00000000);
        @(negedge CLK);
        check("resume_w6_sltu", dmemOut, 32'h00000000);
        @(negedge CLK);
        check("resume_w7_nor",  dmemOut, 32'hFFFFFFFF);
        @(negedge CLK);
        check("resume_w8_lui",  dmemOut, 32'h12340000);
        @(negedge CLK);
        check("resume_w9_ori",  dmemOut, 32'h12340056);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
